// File: rtl/divider_pkg.sv
// Shared processor-wide definitions for the iterative divider.
package divider_pkg;

   // Operand / result width; the divider only supports 32.
   localparam int WIDTH = 32;

   // One quotient bit per iteration.
   localparam int DIV_ITERS = 32;

   // Width of the iteration counter.
   localparam int CNT_W = 6;

   // Quotient reported when the divisor is zero.
   localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   // Divider control states.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_t;

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division iteration: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module divider_div_step
   import divider_pkg::*;
(
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_dvd_msb,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   // The shifted remainder needs a 33rd bit: with a divisor near 2^32 the
   // partial remainder can exceed 2^31 before the shift.
   logic [WIDTH:0]   w_rem_sh;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;

   // Trial subtract. The compare is done at full 33-bit width; when it
   // succeeds the true difference is below the divisor, so the low 32 bits
   // of the modular subtract are already the exact result.
   always_comb begin
      w_rem_sh = {i_rem, i_dvd_msb};
      w_ge     = (w_rem_sh >= {1'b0, i_divisor});
      w_sub    = w_rem_sh[WIDTH-1:0] - i_divisor;
      o_qbit   = w_ge;
      o_rem    = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
   end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU. Operands are reduced to
// magnitudes on start, 32 iterations produce quotient and remainder, and
// the signs are restored combinationally from the registered state.
module divider
   import divider_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   input  logic             is_signed,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_active,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

   div_state_t       r_state;
   div_state_t       w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_a_raw;
   logic             r_signed;
   logic             r_sign_a;
   logic             r_sign_b;
   logic             r_dz;
   logic [WIDTH-1:0] w_rem_next;
   logic             w_qbit;

   // Two's-complement negation.
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + 1'b1;
   endfunction

   // Magnitude of an operand; negated only when it is a signed negative.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
      return neg ? negate(v) : v;
   endfunction

   divider_div_step u_step (
      .i_rem     (r_rem),
      .i_dvd_msb (r_dvd[WIDTH-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_next),
      .o_qbit    (w_qbit)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: start always (re)launches, RUN ends after the last iteration.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (!start && (r_cnt == LAST_ITER)) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Operand capture on start, one restoring iteration per RUN cycle.
   // A start during RUN abandons the current operation and reloads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_dvd     <= '0;
         r_divisor <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_a_raw   <= '0;
         r_signed  <= 1'b0;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_dz      <= 1'b0;
      end else if (start) begin
         r_cnt     <= '0;
         r_dvd     <= magnitude(a, is_signed && a[WIDTH-1]);
         r_divisor <= magnitude(b, is_signed && b[WIDTH-1]);
         r_rem     <= '0;
         r_quot    <= '0;
         r_a_raw   <= a;
         r_signed  <= is_signed;
         r_sign_a  <= a[WIDTH-1];
         r_sign_b  <= b[WIDTH-1];
         r_dz      <= (b == '0);
      end else if (r_state == RUN) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
         r_rem  <= w_rem_next;
         r_quot <= {r_quot[WIDTH-2:0], w_qbit};
      end
   end

   // Sign fix-up and divide-by-zero override, from registered state.
   // A zero divisor reports the raw dividend as remainder regardless of mode.
   always_comb begin
      q = r_quot;
      r = r_rem;
      if (r_dz) begin
         q = DIV_ZERO_Q;
         r = r_a_raw;
      end else begin
         if (r_signed && (r_sign_a ^ r_sign_b)) begin
            q = negate(r_quot);
         end
         if (r_signed && r_sign_a) begin
            r = negate(r_rem);
         end
      end
   end

   assign div_active  = (r_state == RUN);
   assign div_by_zero = r_dz && (r_state == IDLE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, restart, reset abort and
// back-to-back random operations against a behavioural reference.
module tb_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic        start;
   logic        is_signed;
   logic [31:0] q;
   logic [31:0] r;
   logic        div_active;
   logic        div_by_zero;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   localparam int MAX_WAIT = 40;
   localparam int LATENCY  = 32;

   divider dut (
      .clk         (clk),
      .reset       (reset),
      .a           (a),
      .b           (b),
      .start       (start),
      .is_signed   (is_signed),
      .q           (q),
      .r           (r),
      .div_active  (div_active),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Behavioural reference using the language's own division operators.
   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tbv,
                                  input logic s);
      exp_t e;
      e.dz = 1'b0;
      if (tbv == 32'd0) begin
         e.q  = 32'hFFFF_FFFF;
         e.r  = ta;
         e.dz = 1'b1;
      end else if (s) begin
         if (ta == 32'h8000_0000 && tbv == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
         end else begin
            e.q = $signed(ta) / $signed(tbv);
            e.r = $signed(ta) % $signed(tbv);
         end
      end else begin
         e.q = ta / tbv;
         e.r = ta % tbv;
      end
      return e;
   endfunction

   // Drive a one-cycle start and record the expected result.
   // Entered and left one time unit after a rising edge.
   task automatic launch(input logic [31:0] ta, input logic [31:0] tbv,
                         input logic s, input exp_t e);
      a         = ta;
      b         = tbv;
      is_signed = s;
      start     = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges until div_active falls, bounded.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (div_active && cycles < MAX_WAIT) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      start     = 1'b1;
      a         = 32'd100;
      b         = 32'd7;
      is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (div_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_active: got %b want 0", div_active);
      end
      n_cmp++;
      if (q !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_q: got %h want 00000000", q);
      end
      n_cmp++;
      if (r !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_r: got %h want 00000000", r);
      end
      n_cmp++;
      if (div_by_zero !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dz: got %b want 0", div_by_zero);
      end
      start = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (div_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_after: got %b want 0", div_active);
      end
   endtask

   task automatic test_unsigned();
      int   cyc;
      exp_t e;
      launch(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
      wait_done(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (cyc !== LATENCY) begin
         n_fail++;
         $display("FAIL unsigned_latency: got %0d want %0d", cyc, LATENCY);
      end
      n_cmp++;
      if (q !== e.q) begin
         n_fail++;
         $display("FAIL unsigned_q: got %h want %h", q, e.q);
      end
      n_cmp++;
      if (r !== e.r) begin
         n_fail++;
         $display("FAIL unsigned_r: got %h want %h", r, e.r);
      end
      n_cmp++;
      if (div_by_zero !== e.dz) begin
         n_fail++;
         $display("FAIL unsigned_dz: got %b want %b", div_by_zero, e.dz);
      end
   endtask

   task automatic test_signed();
      logic [31:0] ta [2] = '{32'hFFFF_FFF9, 32'h0000_0007};
      logic [31:0] tv [2] = '{32'h0000_0002, 32'hFFFF_FFFE};
      logic [31:0] eq [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD};
      logic [31:0] er [2] = '{32'hFFFF_FFFF, 32'h0000_0001};
      int          cyc;
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         launch(ta[i], tv[i], 1'b1, '{q: eq[i], r: er[i], dz: 1'b0});
         wait_done(cyc);
         e = sb.pop_front();
         n_cmp++;
         if (cyc !== LATENCY) begin
            n_fail++;
            $display("FAIL signed_latency[%0d]: got %0d want %0d", i, cyc, LATENCY);
         end
         n_cmp++;
         if (q !== e.q) begin
            n_fail++;
            $display("FAIL signed_q[%0d]: got %h want %h", i, q, e.q);
         end
         n_cmp++;
         if (r !== e.r) begin
            n_fail++;
            $display("FAIL signed_r[%0d]: got %h want %h", i, r, e.r);
         end
      end
   endtask

   task automatic test_overflow();
      logic        sg [2] = '{1'b1, 1'b0};
      logic [31:0] eq [2] = '{32'h8000_0000, 32'h0000_0000};
      logic [31:0] er [2] = '{32'h0000_0000, 32'h8000_0000};
      int          cyc;
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         launch(32'h8000_0000, 32'hFFFF_FFFF, sg[i], '{q: eq[i], r: er[i], dz: 1'b0});
         wait_done(cyc);
         e = sb.pop_front();
         n_cmp++;
         if (q !== e.q) begin
            n_fail++;
            $display("FAIL overflow_q[%0d]: got %h want %h", i, q, e.q);
         end
         n_cmp++;
         if (r !== e.r) begin
            n_fail++;
            $display("FAIL overflow_r[%0d]: got %h want %h", i, r, e.r);
         end
         n_cmp++;
         if (div_by_zero !== e.dz) begin
            n_fail++;
            $display("FAIL overflow_dz[%0d]: got %b want %b", i, div_by_zero, e.dz);
         end
      end
   endtask

   task automatic test_div_zero();
      logic sg [2] = '{1'b1, 1'b0};
      int   cyc;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         launch(32'd5, 32'd0, sg[i], '{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1});
         wait_done(cyc);
         e = sb.pop_front();
         n_cmp++;
         if (cyc !== LATENCY) begin
            n_fail++;
            $display("FAIL divzero_latency[%0d]: got %0d want %0d", i, cyc, LATENCY);
         end
         n_cmp++;
         if (q !== e.q) begin
            n_fail++;
            $display("FAIL divzero_q[%0d]: got %h want %h", i, q, e.q);
         end
         n_cmp++;
         if (r !== e.r) begin
            n_fail++;
            $display("FAIL divzero_r[%0d]: got %h want %h", i, r, e.r);
         end
         n_cmp++;
         if (div_by_zero !== e.dz) begin
            n_fail++;
            $display("FAIL divzero_flag[%0d]: got %b want %b", i, div_by_zero, e.dz);
         end
      end
   endtask

   task automatic test_restart();
      int   cyc;
      exp_t e;
      launch(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
      repeat (9) @(posedge clk);
      #1;
      // The first operation is abandoned; its result never appears.
      void'(sb.pop_front());
      launch(32'd9, 32'd4, 1'b0, '{q: 32'd2, r: 32'd1, dz: 1'b0});
      wait_done(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (cyc !== LATENCY) begin
         n_fail++;
         $display("FAIL restart_latency: got %0d want %0d", cyc, LATENCY);
      end
      n_cmp++;
      if (q !== e.q) begin
         n_fail++;
         $display("FAIL restart_q: got %h want %h", q, e.q);
      end
      n_cmp++;
      if (r !== e.r) begin
         n_fail++;
         $display("FAIL restart_r: got %h want %h", r, e.r);
      end
   endtask

   task automatic test_reset_mid_run();
      int   cyc;
      exp_t e;
      launch(32'h1234_5678, 32'd3, 1'b1, model(32'h1234_5678, 32'd3, 1'b1));
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      void'(sb.pop_front());
      n_cmp++;
      if (div_active !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_active: got %b want 0", div_active);
      end
      n_cmp++;
      if (q !== 32'd0) begin
         n_fail++;
         $display("FAIL abort_q: got %h want 00000000", q);
      end
      n_cmp++;
      if (r !== 32'd0) begin
         n_fail++;
         $display("FAIL abort_r: got %h want 00000000", r);
      end
      reset = 1'b0;
      launch(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, '{q: 32'd1, r: 32'h7FFF_FFFF, dz: 1'b0});
      wait_done(cyc);
      e = sb.pop_front();
      n_cmp++;
      if (q !== e.q) begin
         n_fail++;
         $display("FAIL post_abort_q: got %h want %h", q, e.q);
      end
      n_cmp++;
      if (r !== e.r) begin
         n_fail++;
         $display("FAIL post_abort_r: got %h want %h", r, e.r);
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      logic [31:0] ta;
      logic [31:0] tv;
      logic        s;
      int          cyc;
      exp_t        e;
      ta = $urandom;
      tv = $urandom_range(1, 1000);
      s  = 1'b1;
      launch(ta, tv, s, model(ta, tv, s));
      for (int i = 0; i < N; i++) begin
         wait_done(cyc);
         e = sb.pop_front();
         n_cmp++;
         if (cyc !== LATENCY) begin
            n_fail++;
            $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, LATENCY);
         end
         n_cmp++;
         if (q !== e.q || r !== e.r) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: got q=%h r=%h want q=%h r=%h",
                     i, q, r, e.q, e.r);
         end
         // Relaunch in the first cycle div_active is low.
         if (i < N - 1) begin
            ta = $urandom;
            tv = (i % 2 == 0) ? $urandom : $urandom_range(1, 1000);
            s  = 1'($urandom_range(0, 1));
            launch(ta, tv, s, model(ta, tv, s));
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      is_signed = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_div_zero();
      test_restart();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit restoring divider for the pipelined processor's execute stage, the inverse companion of the shift-add multiplier. It serves DIV/DIVU: it accepts a dividend and divisor on a one-cycle start pulse and produces one quotient bit per cycle. It delivers quotient and remainder for the HI/LO writeback after a fixed 32-cycle latency. A busy flag lets the hazard unit stall HI/LO consumers.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- a  in  32  dividend, sampled on start.
- b  in  32  divisor, sampled on start.
- start  in  1  one-cycle request pulse; launches a new division.
- is_signed  in  1  sampled on start; 1 = two's-complement (DIV), 0 = unsigned (DIVU).
- q  out  32  quotient (LO).
- r  out  32  remainder (HI).
- div_active  out  1  high while iterations are in progress.
- div_by_zero  out  1  high with the result when the latched divisor was 0.

## Operation
- States: IDLE, RUN. reset -> IDLE.
- IDLE + start: latch sign flag, a[31], b[31] and is_signed. Latch magnitude |a| into the dividend shift register and |b| into the divisor register; take the two's-complement magnitude only when is_signed and the sign bit is set. Clear the partial remainder, clear the 6-bit iteration counter and go to RUN.
- RUN, each cycle:
  - rem' = {rem[30:0], dvd[31]}, dvd <<= 1.
  - If rem' >= divisor: rem = rem' - divisor and shift 1 into the quotient LSB; else rem = rem' and shift in 0.
  - Use a 33-bit subtract so a divisor of 0x80000000 is handled.
  - counter++. After the 32nd iteration, go to IDLE.
- Result fix-up, combinational from registers:
  - q = negate(quot) if signed && (signA ^ signB).
  - r = negate(rem) if signed && signA.
- Divisor zero:
  - q = 0xFFFFFFFF, r = a as latched (raw, unsigned view), div_by_zero = 1, for both signed and unsigned.
  - Timing is unchanged (still 32 cycles).
- Signed overflow (0x80000000 / 0xFFFFFFFF): falls out of the magnitude path as q = 0x80000000, r = 0. No special case and no flag.
- start while RUN: abandon the current operation, reload operands and restart the count. The hazard unit is responsible for not doing this, but behaviour is defined.
- q, r and div_by_zero hold their last value in IDLE until the next start edge. In RUN they are don't-care to consumers.

## Timing
- Start sampled at edge t0; iterations at edges t1..t32.
- div_active = 1 for exactly 32 cycles, from after t0 through t32. It falls after t32, when q/r/div_by_zero are valid.
- Back-to-back: start may be asserted in the first cycle div_active is low. It yields another 32-cycle window with no idle gap.
- Reset values: q = 0, r = 0, div_active = 0, div_by_zero = 0, state IDLE, counter 0.
- Reset has priority over start in the same cycle. Reset mid-RUN aborts the operation; outputs return to reset values the next cycle.

## Structure
- Shared package (processor-wide):
  - WIDTH.
  - State encoding {IDLE, RUN}.
  - DIV_ITERS = 32.
  - DIV_ZERO_Q = 32'hFFFFFFFF.
- One sub-module, div_step: purely combinational single restoring iteration. Inputs {rem, dvd MSB, divisor}; outputs {next rem, quotient bit}. The top holds the FSM, counter, operand registers and sign fix-up.

## Test plan
- Unsigned 100 / 7, is_signed = 0 -> q = 14, r = 2; div_active high exactly 32 cycles; div_by_zero = 0.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> q = 0xFFFFFFFD (-3), r = 0xFFFFFFFF (-1). Signed 7 / -2 -> q = -3, r = 1.
- 0x80000000 / 0xFFFFFFFF:
  - Signed -> q = 0x80000000, r = 0.
  - Unsigned -> q = 0, r = 0x80000000.
- Divisor zero: 5 / 0, signed and unsigned -> q = 0xFFFFFFFF, r = 5, div_by_zero = 1 after 32 cycles.
- start 100 / 7, then start 9 / 4 at cycle 10 of RUN -> result q = 2, r = 1 valid 32 cycles after the second start.
- Reset at cycle 15 of RUN -> div_active = 0, q = r = 0 next cycle. A subsequent 0xFFFFFFFF / 0x80000000 unsigned -> q = 1, r = 0x7FFFFFFF.
